// File: rtl/bicubic_block_collector.sv
// Collects two 8-pixel upsampler beats per 4x4 block into a ping-pong buffer
// and streams each finished block out as four row words.

module bicubic_block_bank #(
  parameter int ROW_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic                      wr_beat,
  input  logic [ROW_WIDTH-1:0]      row_a,
  input  logic [ROW_WIDTH-1:0]      row_b,
  output logic [3:0][ROW_WIDTH-1:0] rows
);
  // Beat 0 fills rows 0/1, beat 1 fills rows 2/3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows <= '0;
    end else if (wr_en) begin
      rows[{wr_beat, 1'b0}] <= row_a;
      rows[{wr_beat, 1'b1}] <= row_b;
    end
  end
endmodule

module bicubic_block_collector #(
  parameter  int CHANNEL_WIDTH = 8,
  localparam int ROW_WIDTH     = 4 * CHANNEL_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bcci_rsp_valid,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data1,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data2,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data3,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data4,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data5,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data6,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data7,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data8,
  output logic                     clt_rsp_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROW_WIDTH-1:0]     out_data,
  output logic [1:0]               out_row,
  output logic                     out_last
);
  logic                            wr_bank, wr_beat, rd_bank;
  logic [1:0]                      rd_row;
  logic [1:0]                      bank_full, full_nxt;
  logic                            in_hs, out_hs;
  logic [ROW_WIDTH-1:0]            row_a, row_b;
  logic [1:0][3:0][ROW_WIDTH-1:0]  bank_rows;

  assign row_a = {bcci_rsp_data4, bcci_rsp_data3, bcci_rsp_data2, bcci_rsp_data1};
  assign row_b = {bcci_rsp_data8, bcci_rsp_data7, bcci_rsp_data6, bcci_rsp_data5};

  // Ready comes only from registered state, so no valid->ready loop upstream.
  assign clt_rsp_ready = ~bank_full[wr_bank];
  assign in_hs         = bcci_rsp_valid & clt_rsp_ready;

  assign out_valid = bank_full[rd_bank];
  assign out_hs    = out_valid & out_ready;
  assign out_data  = bank_rows[rd_bank][rd_row];
  assign out_row   = rd_row;
  assign out_last  = out_valid & (rd_row == 2'd3);

  for (genvar g = 0; g < 2; g++) begin : g_bank
    bicubic_block_bank #(.ROW_WIDTH(ROW_WIDTH)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_hs & (wr_bank == 1'(g))),
      .wr_beat (wr_beat),
      .row_a   (row_a),
      .row_b   (row_b),
      .rows    (bank_rows[g])
    );
  end

  // Write completion and read completion always hit different banks.
  always_comb begin
    full_nxt = bank_full;
    if (in_hs && wr_beat)              full_nxt[wr_bank] = 1'b1;
    if (out_hs && (rd_row == 2'd3))    full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      wr_beat   <= 1'b0;
      rd_bank   <= 1'b0;
      rd_row    <= 2'd0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= full_nxt;
      if (in_hs) begin
        wr_beat <= ~wr_beat;
        if (wr_beat) wr_bank <= ~wr_bank;
      end
      if (out_hs) begin
        rd_row <= rd_row + 2'd1;
        if (rd_row == 2'd3) rd_bank <= ~rd_bank;
      end
    end
  end
endmodule

// File: doc/bicubic_block_collector.md
Name: bicubic_block_collector

Overview:
- Downstream neighbour of the 2x bicubic upsampler. Consumes its two 8-pixel response beats per input window: beat 0 carries output rows 0/1 and beat 1 carries output rows 2/3 of a 4x4 output block.
- Assembles each 4x4 block in a ping-pong (two-bank) buffer and emits it as four row words, one per handshake, to the output writer.
- Acts as the `bf_rsp_ready` source seen by the upsampler.

Parameters:
- CHANNEL_WIDTH, 8, bits per pixel channel.
- ROW_WIDTH, 4*CHANNEL_WIDTH, width of one emitted output row word (derived; must not be overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bcci_rsp_valid  input  1  upsampler response valid.
- bcci_rsp_data1..bcci_rsp_data4  input  CHANNEL_WIDTH each  upper row of the beat, pixel 1 leftmost.
- bcci_rsp_data5..bcci_rsp_data8  input  CHANNEL_WIDTH each  lower row of the beat, pixel 5 leftmost.
- clt_rsp_ready  output  1  collector can accept a beat; drives upsampler bf_rsp_ready.
- out_valid  output  1  out_data holds a valid row word.
- out_ready  input  1  downstream accepts row word.
- out_data  output  ROW_WIDTH  row word; bits [CW-1:0] = leftmost pixel, ascending to the right.
- out_row  output  2  row index 0..3 within the current block.
- out_last  output  1  high with row 3 (block end).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all state cleared.
  - wr_bank=0, wr_beat=0, rd_bank=0, rd_row=0, bank_full=2'b00, bank contents 0.
  - Outputs after reset: clt_rsp_ready=1, out_valid=0, out_data=0, out_row=0, out_last=0.
- Input handshake: in_hs = bcci_rsp_valid & clt_rsp_ready.
  - clt_rsp_ready = ~bank_full[wr_bank]. It is a registered-state function and never depends on bcci_rsp_valid.
- On in_hs with wr_beat=0: data1..4 are written to row 0 and data5..8 to row 1 of bank wr_bank; then wr_beat<=1.
- On in_hs with wr_beat=1: data1..4 are written to row 2 and data5..8 to row 3; then wr_beat<=0, bank_full[wr_bank]<=1, wr_bank toggles.
- Beat phase is tracked locally and advances only on in_hs, so it stays aligned with the upsampler S1/S2 FSM, which advances on the same handshake.
- Output side:
  - out_valid = bank_full[rd_bank].
  - out_data = row rd_row of bank rd_bank.
  - out_row = rd_row.
  - out_last = out_valid & (rd_row==3).
- Output handshake: out_hs = out_valid & out_ready.
  - On out_hs, rd_row increments.
  - On out_hs with rd_row=3: rd_row<=0, bank_full[rd_bank]<=0, rd_bank toggles.
- out_data/out_row/out_last must hold stable while out_valid & ~out_ready.
- Latency:
  - First row word is valid the cycle after the beat-1 handshake.
  - A bank freed by an out_hs is writable the cycle after that handshake; there is no combinational ready-to-ready path.
- Throughput: 2 input beats plus 4 output rows per block. With out_ready tied high, sustained rate is one block per 4 cycles; the input stalls 2 of every 4 cycles in steady state.
- Full condition: both banks full gives clt_rsp_ready=0. A valid beat is held off and no state changes.
- Empty condition: both banks empty gives out_valid=0. out_data shows the stale bank contents and must be ignored.
- Simultaneous in_hs completing bank X and out_hs finishing bank Y (Y≠X): both bank_full updates apply in the same cycle. X and Y are always different banks, because writes target only a non-full bank and reads only a full one.
- Partial block: after beat 0, bank_full is unchanged. Rows 0/1 sit in the bank until beat 1 arrives, with no timeout.
- Reset mid-block, asserted at any time: partial and full blocks are discarded and outputs return to reset values asynchronously. The upsampler FSM is reset from the same reset net, so phases stay aligned.
- No arithmetic: pixels pass through unmodified and width is preserved.

Test Plan:
- Single block, out_ready=1: beat0 data1..8 = 0x01..0x08, beat1 = 0x11..0x18 on consecutive cycles.
  - Output rows: 0x04030201, 0x08070605, 0x14131211, 0x18171615; out_row 0..3; out_last only on the 4th row.
  - First out_valid appears 1 cycle after beat1.
- Back-pressure fill, out_ready=0: offer 6 beats continuously.
  - Exactly 4 beats accepted (2 blocks); clt_rsp_ready=0 from the cycle after the 4th handshake.
  - Out_data stays 0x04030201 throughout.
  - Raising out_ready drains 8 rows in order, and clt_rsp_ready reasserts the cycle after the 4th row handshake.
- Streaming, out_ready=1, bcci_rsp_valid=1 constant, 8 blocks with incrementing data.
  - 32 rows emitted in order with no duplicates or drops; steady state is one row per cycle.
- Output stall on row 2 (out_ready low 3 cycles): out_data/out_row hold at row 2; no advance until the handshake.
- Partial block then reset: accept beat0 only, assert rst for 1 cycle.
  - out_valid=0 and clt_rsp_ready=1 immediately.
  - The next two beats form a fresh block whose rows 0/1 come from the new beat0, not the stale data.
- Simultaneous write-complete and read-complete: bank1 beat1 handshake in the same cycle as the bank0 row-3 handshake.
  - Next cycle: bank_full=2'b10 and rd_bank=1 with out_valid=1.
